// File: rtl/uart_pkg.sv
// Shared frame-layout constants and sequencer state encoding for the UART receive path.
package uart_pkg;

    localparam int UART_FRAME_W  = 9;
    localparam int UART_PERR_BIT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DISCARD = 2'd2
    } rx_fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W simple dual-port RAM: synchronous write, registered synchronous read.
module uart_fifo_mem #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              CLK288MHZ,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [AW-1:0]     wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [AW-1:0]     rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK288MHZ) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Only the read register is reset so the reader sees a defined zero after reset.
    always_ff @(posedge CLK288MHZ) begin
        if (!reset) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/uart_rx_commit_fifo.sv
// Receive FIFO with speculative write/commit/rollback sequencing, parity-drop policy,
// and sticky error flags plus saturating error counters.
module uart_rx_commit_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH           = 16,
    parameter  bit DROP_PARITY_ERR = 1'b1,
    localparam int AW              = $clog2(DEPTH)
) (
    input  logic                    CLK288MHZ,
    input  logic                    reset,
    input  logic [UART_FRAME_W-1:0] rx_data,
    input  logic                    rx_write_en,
    input  logic                    rx_commit,
    input  logic                    rx_rollback,
    input  logic                    rd_req,
    input  logic                    clr_flags,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    output logic                    empty,
    output logic                    full,
    output logic [AW:0]             count,
    output logic                    overflow,
    output logic                    proto_err,
    output logic [7:0]              parity_err_cnt,
    output logic [7:0]              frame_err_cnt
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    rx_fifo_state_t state, nextState;
    logic [AW:0]    wrPtr, rdPtr;
    logic           pendPerr;
    logic           memWe, wrAdvance, incFrameErr, incParityErr, setOverflow, setProtoErr;
    logic           rdAccept;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Occupancy counts committed entries only; the pending slot sits at wrPtr, outside it.
    assign count    = wrPtr - rdPtr;
    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign rdAccept = rd_req && !empty;

    always_comb begin
        nextState    = state;
        memWe        = 1'b0;
        wrAdvance    = 1'b0;
        incFrameErr  = 1'b0;
        incParityErr = 1'b0;
        setOverflow  = 1'b0;
        setProtoErr  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_write_en) begin
                    if (!full) begin
                        memWe     = 1'b1;
                        nextState = PENDING;
                    end else begin
                        setOverflow = 1'b1;
                        nextState   = DISCARD;
                    end
                end
            end
            PENDING: begin
                if (rx_rollback) begin
                    incFrameErr = 1'b1;
                    nextState   = IDLE;
                end else if (rx_commit) begin
                    incParityErr = pendPerr;
                    wrAdvance    = !(pendPerr && DROP_PARITY_ERR);
                    nextState    = IDLE;
                end else if (rx_write_en) begin
                    setProtoErr = 1'b1;
                    memWe       = 1'b1;
                end
            end
            DISCARD: begin
                if (rx_commit || rx_rollback) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Set/increment events take priority over clr_flags in the same cycle.
    always_ff @(posedge CLK288MHZ) begin
        if (!reset) begin
            state          <= IDLE;
            wrPtr          <= '0;
            rdPtr          <= '0;
            rd_valid       <= 1'b0;
            overflow       <= 1'b0;
            proto_err      <= 1'b0;
            parity_err_cnt <= '0;
            frame_err_cnt  <= '0;
        end else begin
            state    <= nextState;
            rd_valid <= rdAccept;
            if (wrAdvance) wrPtr <= wrPtr + PTR_ONE;
            if (rdAccept)  rdPtr <= rdPtr + PTR_ONE;

            if (setOverflow)    overflow <= 1'b1;
            else if (clr_flags) overflow <= 1'b0;

            if (setProtoErr)    proto_err <= 1'b1;
            else if (clr_flags) proto_err <= 1'b0;

            if (incParityErr)   parity_err_cnt <= satInc(parity_err_cnt);
            else if (clr_flags) parity_err_cnt <= '0;

            if (incFrameErr)    frame_err_cnt <= satInc(frame_err_cnt);
            else if (clr_flags) frame_err_cnt <= '0;
        end
    end

    always_ff @(posedge CLK288MHZ) begin
        if (memWe) begin
            pendPerr <= rx_data[UART_PERR_BIT];
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) uMem (
        .CLK288MHZ (CLK288MHZ),
        .reset     (reset),
        .wrEn      (memWe),
        .wrAddr    (wrPtr[AW-1:0]),
        .wrData    (rx_data[7:0]),
        .rdEn      (rdAccept),
        .rdAddr    (rdPtr[AW-1:0]),
        .rdData    (rd_data)
    );

endmodule
